// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer.
// A word that is already held is chained straight onto the end of the previous word, so there is no idle cycle on the line.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdo,
    output logic             sframe,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_sdo;
    logic             r_sframe;
    logic             r_done;

    logic w_accept;
    logic w_last;
    logic w_load;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Accept needs an empty buffer and a load needs a full one, so the two never coincide.
    assign w_accept = in_valid & ~r_hold_full;
    assign w_last   = (r_state == SHIFT) && (r_count == LAST);
    assign w_load   = r_hold_full & ((r_state == IDLE) | w_last);

    assign in_ready = ~r_hold_full;
    assign sdo      = r_sdo;
    assign sframe   = r_sframe;
    assign done     = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_hold_full) w_state_nxt = SHIFT;
            SHIFT:   if (w_last && !r_hold_full) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_count     <= '0;
            r_sdo       <= 1'b0;
            r_sframe    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            // r_shift holds only the bits not yet put on the line.
            if (w_load) begin
                r_sdo    <= first_bit(r_hold);
                r_shift  <= advance(r_hold);
                r_sframe <= 1'b1;
                r_count  <= '0;
                r_done   <= 1'b0;
            end else if (r_state == SHIFT && !w_last) begin
                r_sdo    <= first_bit(r_shift);
                r_shift  <= advance(r_shift);
                r_count  <= r_count + 1'b1;
                r_done   <= (r_count == PENULT);
            end else begin
                r_sdo    <= 1'b0;
                r_sframe <= 1'b0;
                r_count  <= '0;
                r_done   <= 1'b0;
            end
        end
    end

endmodule
